// File: rtl/lnrv_itcm_rsp.sv
// -----------------------------------------------------------------------------
// lnrv_itcm_rsp
//
// Responder end of the instruction-TCM cmd/rsp bus. Each accepted command is
// decoded and range-checked, drives a single-port synchronous SRAM macro
// (1-cycle read latency), and produces exactly one in-order response. Read data
// is returned straight through in the cycle after the command when the response
// buffer is empty. Otherwise it is captured into a 2-entry FIFO so that
// response stalls never lose SRAM read data.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   itcm_cmd_*         command channel (vld/rdy handshake, write, addr, wdata, wstrb)
//   itcm_rsp_*         response channel (vld/rdy handshake, rdata, err)
//   ram_cs/we/addr/wdata/wem  SRAM macro drive
//   ram_rdata          SRAM read data, valid the cycle after a read
// -----------------------------------------------------------------------------
module lnrv_itcm_rsp #(
    parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
    parameter int          RAM_AW    = 14
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              itcm_cmd_vld,
    output logic              itcm_cmd_rdy,
    input  logic              itcm_cmd_write,
    input  logic [31:0]       itcm_cmd_addr,
    input  logic [31:0]       itcm_cmd_wdata,
    input  logic [3:0]        itcm_cmd_wstrb,

    output logic              itcm_rsp_vld,
    input  logic              itcm_rsp_rdy,
    output logic [31:0]       itcm_rsp_rdata,
    output logic              itcm_rsp_err,

    output logic              ram_cs,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_wem,
    input  logic [31:0]       ram_rdata
);

    localparam logic [31:0] WIN_SIZE = 32'd4 << RAM_AW;

    // ------------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------------
    logic [31:0] offset;
    logic        cmd_err;
    logic        accept;

    // Unsigned wrap makes addresses below the base land far above WIN_SIZE,
    // so one compare covers both ends of the window.
    assign offset  = itcm_cmd_addr - ADDR_BASE;
    assign cmd_err = (itcm_cmd_addr[1:0] != 2'b00) || (offset >= WIN_SIZE);

    // ------------------------------------------------------------------------
    // State: in-flight stage and 2-entry response FIFO
    // ------------------------------------------------------------------------
    logic        infl_vld;
    logic        infl_write;
    logic        infl_err;

    logic [1:0]  count;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [31:0] fifo_rdata [2];
    logic        fifo_err   [2];

    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic [31:0] infl_rdata;
    logic        infl_rsp_err;

    // Ready depends only on registered occupancy: at most two responses
    // (one in flight, the rest buffered) may be outstanding at any time.
    assign itcm_cmd_rdy = ((2'(infl_vld) + count) < 2'd2);
    assign accept       = itcm_cmd_vld & itcm_cmd_rdy & ~reset;

    // ------------------------------------------------------------------------
    // SRAM drive (same cycle as accept). Erroring commands never select it.
    // ------------------------------------------------------------------------
    assign ram_cs    = accept & ~cmd_err;
    assign ram_we    = ram_cs & itcm_cmd_write;
    assign ram_addr  = offset[RAM_AW+1:2];
    assign ram_wdata = itcm_cmd_wdata;
    assign ram_wem   = itcm_cmd_write ? itcm_cmd_wstrb : 4'b0000;

    // ------------------------------------------------------------------------
    // Response value of the in-flight command. ram_rdata is only meaningful
    // this one cycle, so it is gated here and captured if it cannot leave.
    // ------------------------------------------------------------------------
    assign infl_rdata   = (infl_vld && !infl_write && !infl_err) ? ram_rdata : 32'h0;
    assign infl_rsp_err = infl_vld & infl_err;

    assign fifo_empty = (count == 2'd0);
    assign pop        = ~fifo_empty & itcm_rsp_rdy;
    // The in-flight response bypasses only when nothing older is waiting
    // and the consumer takes it now; otherwise it joins the FIFO tail.
    assign push       = infl_vld & ~(fifo_empty & itcm_rsp_rdy);

    // NOTE: always_comb assigns every output a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        itcm_rsp_vld   = infl_vld;
        itcm_rsp_rdata = infl_rdata;
        itcm_rsp_err   = infl_rsp_err;
        if (!fifo_empty) begin
            itcm_rsp_vld   = 1'b1;
            itcm_rsp_rdata = fifo_rdata[rd_ptr];
            itcm_rsp_err   = fifo_err[rd_ptr];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            infl_vld   <= 1'b0;
            infl_write <= 1'b0;
            infl_err   <= 1'b0;
            count      <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
        end else begin
            infl_vld   <= accept;
            infl_write <= itcm_cmd_write;
            infl_err   <= cmd_err;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            // Simultaneous push and pop leaves count unchanged.
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // NOTE: FIFO storage carries no reset; count and pointers alone decide
    // which entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rdata[wr_ptr] <= infl_rdata;
            fifo_err[wr_ptr]   <= infl_err;
        end
    end

endmodule

// File: tb/tb_lnrv_itcm_rsp.sv
// -----------------------------------------------------------------------------
// tb_lnrv_itcm_rsp
//
// Self-checking bench for lnrv_itcm_rsp. A behavioural SRAM answers the macro
// port. A reference model (expected-memory array plus a queue of expected
// responses) is updated at each accepted command and checks every response,
// the ready flag, SRAM selection and response stability. Scenario tasks add
// their own directed checks.
// -----------------------------------------------------------------------------
module tb_lnrv_itcm_rsp;

    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          RAM_AW = 14;
    localparam int          WORDS  = 1 << RAM_AW;

    logic              clk = 1'b0;
    logic              reset;
    logic              itcm_cmd_vld;
    logic              itcm_cmd_rdy;
    logic              itcm_cmd_write;
    logic [31:0]       itcm_cmd_addr;
    logic [31:0]       itcm_cmd_wdata;
    logic [3:0]        itcm_cmd_wstrb;
    logic              itcm_rsp_vld;
    logic              itcm_rsp_rdy;
    logic [31:0]       itcm_rsp_rdata;
    logic              itcm_rsp_err;
    logic              ram_cs;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_wem;
    logic [31:0]       ram_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lnrv_itcm_rsp #(.ADDR_BASE(BASE), .RAM_AW(RAM_AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .itcm_cmd_vld   (itcm_cmd_vld),
        .itcm_cmd_rdy   (itcm_cmd_rdy),
        .itcm_cmd_write (itcm_cmd_write),
        .itcm_cmd_addr  (itcm_cmd_addr),
        .itcm_cmd_wdata (itcm_cmd_wdata),
        .itcm_cmd_wstrb (itcm_cmd_wstrb),
        .itcm_rsp_vld   (itcm_rsp_vld),
        .itcm_rsp_rdy   (itcm_rsp_rdy),
        .itcm_rsp_rdata (itcm_rsp_rdata),
        .itcm_rsp_err   (itcm_rsp_err),
        .ram_cs         (ram_cs),
        .ram_we         (ram_we),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_wem        (ram_wem),
        .ram_rdata      (ram_rdata)
    );

    // ------------------------------------------------------------------------
    // Behavioural SRAM macro: data appears the cycle after a read and is junk
    // otherwise, so a late sample of ram_rdata shows up as bad data.
    // ------------------------------------------------------------------------
    logic [31:0] sram [WORDS];

    always @(posedge clk) begin
        if (ram_cs && ram_we) begin
            for (int b = 0; b < 4; b++)
                if (ram_wem[b]) sram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= $urandom;
        end else if (ram_cs) begin
            ram_rdata <= sram[ram_addr];
        end else begin
            ram_rdata <= $urandom;
        end
    end

    // ------------------------------------------------------------------------
    // Reference model: expected memory and expected response queue.
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic [31:0] exp_mem [WORDS];
    rsp_t        exp_q [$];
    int          rsp_count = 0;
    int          cs_count  = 0;
    logic [31:0] last_rdata;
    logic        prev_stall = 1'b0;
    rsp_t        prev_rsp;

    function automatic logic addr_err(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a % 4 != 0) || (off >= 32'h0001_0000);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            // Outstanding responses (accepted, not yet delivered) decide ready.
            n_checks++;
            if (itcm_cmd_rdy !== (exp_q.size() < 2)) begin
                n_fail++;
                $display("FAIL cmd_rdy: got %b expected %b (outstanding %0d)",
                         itcm_cmd_rdy, exp_q.size() < 2, exp_q.size());
            end

            if (prev_stall) begin
                n_checks++;
                if (itcm_rsp_vld !== 1'b1 || itcm_rsp_rdata !== prev_rsp.rdata ||
                    itcm_rsp_err !== prev_rsp.err) begin
                    n_fail++;
                    $display("FAIL rsp_stable: got vld %b rdata %h err %b expected vld 1 rdata %h err %b",
                             itcm_rsp_vld, itcm_rsp_rdata, itcm_rsp_err, prev_rsp.rdata, prev_rsp.err);
                end
            end
            prev_stall = itcm_rsp_vld & ~itcm_rsp_rdy;
            prev_rsp   = '{rdata: itcm_rsp_rdata, err: itcm_rsp_err};

            if (itcm_rsp_vld === 1'b1 && itcm_rsp_rdy) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected: got rdata %h err %b expected no response",
                             itcm_rsp_rdata, itcm_rsp_err);
                end else begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    if (itcm_rsp_rdata !== e.rdata || itcm_rsp_err !== e.err) begin
                        n_fail++;
                        $display("FAIL rsp_data: got rdata %h err %b expected rdata %h err %b",
                                 itcm_rsp_rdata, itcm_rsp_err, e.rdata, e.err);
                    end
                end
                rsp_count++;
                last_rdata = itcm_rsp_rdata;
            end

            if (ram_cs === 1'b1) cs_count++;

            if (itcm_cmd_vld && itcm_cmd_rdy === 1'b1) begin
                logic e_err;
                rsp_t r;
                int   w;
                e_err = addr_err(itcm_cmd_addr);
                w     = word_of(itcm_cmd_addr);
                r.err   = e_err;
                r.rdata = (!e_err && !itcm_cmd_write) ? exp_mem[w] : 32'h0;
                exp_q.push_back(r);
                if (!e_err && itcm_cmd_write)
                    for (int b = 0; b < 4; b++)
                        if (itcm_cmd_wstrb[b]) exp_mem[w][8*b +: 8] = itcm_cmd_wdata[8*b +: 8];

                n_checks++;
                if (ram_cs !== !e_err) begin
                    n_fail++;
                    $display("FAIL ram_cs_accept: got %b expected %b addr %h", ram_cs, !e_err, itcm_cmd_addr);
                end else if (!e_err) begin
                    n_checks++;
                    if (ram_we !== itcm_cmd_write || ram_addr !== RAM_AW'(w) ||
                        (itcm_cmd_write && (ram_wem !== itcm_cmd_wstrb || ram_wdata !== itcm_cmd_wdata))) begin
                        n_fail++;
                        $display("FAIL ram_drive: got we %b addr %h wem %h expected we %b addr %h wem %h",
                                 ram_we, ram_addr, ram_wem, itcm_cmd_write, RAM_AW'(w), itcm_cmd_wstrb);
                    end
                end
            end else begin
                n_checks++;
                if (ram_cs !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ram_cs_idle: got %b expected 0", ram_cs);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s);
        itcm_cmd_vld   = 1'b1;
        itcm_cmd_write = w;
        itcm_cmd_addr  = a;
        itcm_cmd_wdata = d;
        itcm_cmd_wstrb = s;
    endtask

    // Holds the command until accepted; returns one tick after the accepting edge.
    task automatic send(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        bit done = 0;
        drive_cmd(w, a, d, s);
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (itcm_cmd_rdy) done = 1;
            step();
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no accept expected accept addr %h", a);
        end
        itcm_cmd_vld = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !itcm_rsp_vld) done = 1;
            step();
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", exp_q.size());
        end
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        itcm_cmd_vld = 1'b0; itcm_cmd_write = 1'b0; itcm_cmd_addr = '0;
        itcm_cmd_wdata = '0; itcm_cmd_wstrb = '0; itcm_rsp_rdy = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (itcm_rsp_vld !== 1'b0 || itcm_rsp_rdata !== 32'h0 || itcm_rsp_err !== 1'b0 ||
            ram_cs !== 1'b0 || ram_we !== 1'b0 || itcm_cmd_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_values: got vld %b rdata %h err %b cs %b we %b rdy %b expected 0 0 0 0 0 1",
                     itcm_rsp_vld, itcm_rsp_rdata, itcm_rsp_err, ram_cs, ram_we, itcm_cmd_rdy);
        end
        step();
    endtask

    task automatic test_read_after_write();
        itcm_rsp_rdy = 1'b1;
        drive_cmd(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk);
        step();
        drive_cmd(1'b0, 32'h8000_0010, 32'h0, 4'h0);
        @(negedge clk);
        n_checks++;
        if (itcm_rsp_vld !== 1'b1 || itcm_rsp_rdata !== 32'h0 || itcm_rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_write_rsp: got vld %b rdata %h err %b expected 1 00000000 0",
                     itcm_rsp_vld, itcm_rsp_rdata, itcm_rsp_err);
        end
        step();
        itcm_cmd_vld = 1'b0;
        @(negedge clk);
        n_checks++;
        if (itcm_rsp_vld !== 1'b1 || itcm_rsp_rdata !== 32'hDEAD_BEEF || itcm_rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_read_rsp: got vld %b rdata %h err %b expected 1 deadbeef 0",
                     itcm_rsp_vld, itcm_rsp_rdata, itcm_rsp_err);
        end
        step();
        wait_drain();
    endtask

    task automatic test_byte_strobes();
        itcm_rsp_rdy = 1'b1;
        send(1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'hF);
        send(1'b1, 32'h8000_0020, 32'h1122_3344, 4'h5);
        send(1'b0, 32'h8000_0020, 32'h0, 4'h0);
        wait_drain();
        n_checks++;
        if (last_rdata !== 32'hFF22_FF44) begin
            n_fail++;
            $display("FAIL byte_strobes: got %h expected ff22ff44", last_rdata);
        end
        // Zero strobes still select the SRAM and leave the word untouched.
        send(1'b1, 32'h8000_0020, 32'h0000_0000, 4'h0);
        send(1'b0, 32'h8000_0020, 32'h0, 4'h0);
        wait_drain();
        n_checks++;
        if (last_rdata !== 32'hFF22_FF44) begin
            n_fail++;
            $display("FAIL zero_strobes: got %h expected ff22ff44", last_rdata);
        end
    endtask

    task automatic test_errors();
        logic [31:0] bad [4];
        bad[0] = 32'h8001_0000;
        bad[1] = 32'h7FFF_FFFC;
        bad[2] = 32'h8000_0002;
        bad[3] = 32'hFFFF_FFFC;
        itcm_rsp_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int cs0;
            cs0 = cs_count;
            send(i == 3, bad[i], 32'h5555_AAAA, 4'hF);
            @(negedge clk);
            n_checks++;
            if (itcm_rsp_vld !== 1'b1 || itcm_rsp_err !== 1'b1 || itcm_rsp_rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL err_rsp: addr %h got vld %b err %b rdata %h expected 1 1 00000000",
                         bad[i], itcm_rsp_vld, itcm_rsp_err, itcm_rsp_rdata);
            end
            n_checks++;
            if (cs_count != cs0) begin
                n_fail++;
                $display("FAIL err_no_sram: addr %h got %0d selects expected 0", bad[i], cs_count - cs0);
            end
            step();
        end
        // Last word of the window is still legal.
        send(1'b0, 32'h8000_FFFC, 32'h0, 4'h0);
        wait_drain();
    endtask

    task automatic test_back_pressure();
        logic [31:0] a [4];
        int n = 0;
        int r0;
        for (int i = 0; i < 4; i++) a[i] = BASE + ($urandom_range(0, 63) << 2);
        itcm_rsp_rdy = 1'b0;
        r0 = rsp_count;
        drive_cmd(1'b0, a[0], 32'h0, 4'h0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (itcm_cmd_rdy) n++;
            step();
            if (n < 4) itcm_cmd_addr = a[n]; else itcm_cmd_vld = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (n != 2 || itcm_cmd_rdy !== 1'b0 || itcm_rsp_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_full: got accepts %0d rdy %b vld %b expected 2 0 1", n, itcm_cmd_rdy, itcm_rsp_vld);
        end
        step();
        itcm_rsp_rdy = 1'b1;
        for (int c = 0; c < 20 && n < 4; c++) begin
            @(negedge clk);
            if (itcm_cmd_rdy) n++;
            step();
            if (n < 4) itcm_cmd_addr = a[n]; else itcm_cmd_vld = 1'b0;
        end
        itcm_cmd_vld = 1'b0;
        wait_drain();
        n_checks++;
        if (rsp_count - r0 != 4) begin
            n_fail++;
            $display("FAIL bp_count: got %0d responses expected 4", rsp_count - r0);
        end
    endtask

    task automatic test_streaming();
        int r0;
        r0 = rsp_count;
        itcm_rsp_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_cmd(1'b0, BASE + ($urandom_range(0, 1023) << 2), 32'h0, 4'h0);
            @(negedge clk);
            n_checks++;
            if (itcm_cmd_rdy !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_rdy: beat %0d got %b expected 1", i, itcm_cmd_rdy);
            end
            if (i > 0) begin
                n_checks++;
                if (itcm_rsp_vld !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stream_vld: beat %0d got %b expected 1", i, itcm_rsp_vld);
                end
            end
            step();
        end
        itcm_cmd_vld = 1'b0;
        @(negedge clk);
        n_checks++;
        if (itcm_rsp_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_last: got %b expected 1", itcm_rsp_vld);
        end
        step();
        wait_drain();
        n_checks++;
        if (rsp_count - r0 != 8) begin
            n_fail++;
            $display("FAIL stream_count: got %0d responses expected 8", rsp_count - r0);
        end
    endtask

    task automatic test_reset_midop();
        itcm_rsp_rdy = 1'b0;
        drive_cmd(1'b0, BASE + 32'h40, 32'h0, 4'h0);
        step();
        itcm_cmd_addr = BASE + 32'h44;
        step();
        itcm_cmd_vld = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        @(negedge clk);
        n_checks++;
        if (itcm_rsp_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_vld: got %b expected 0", itcm_rsp_vld);
        end
        step();
        reset = 1'b0;
        itcm_rsp_rdy = 1'b1;
        @(negedge clk);
        n_checks++;
        if (itcm_cmd_rdy !== 1'b1 || itcm_rsp_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_release: got rdy %b vld %b expected 1 0", itcm_cmd_rdy, itcm_rsp_vld);
        end
        step();
        repeat (5) step();
    endtask

    task automatic test_random();
        logic acc = 1'b1;
        int r0;
        r0 = rsp_count;
        for (int c = 0; c < 400; c++) begin
            itcm_rsp_rdy = ($urandom_range(0, 3) != 0);
            if (!itcm_cmd_vld || acc) begin
                int k;
                logic [31:0] a;
                k = $urandom_range(0, 9);
                if (k == 0)      a = BASE + ($urandom_range(0, 31) << 2) + 32'($urandom_range(1, 3));
                else if (k == 1) a = BASE + 32'h0001_0000 + ($urandom_range(0, 255) << 2);
                else if (k == 2) a = BASE - 32'(($urandom_range(1, 255)) << 2);
                else             a = BASE + ($urandom_range(0, 31) << 2);
                drive_cmd($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom));
                itcm_cmd_vld = ($urandom_range(0, 2) != 0);
            end
            @(negedge clk);
            acc = itcm_cmd_vld & itcm_cmd_rdy;
            step();
        end
        itcm_cmd_vld = 1'b0;
        itcm_rsp_rdy = 1'b1;
        wait_drain();
        n_checks++;
        if (rsp_count == r0) begin
            n_fail++;
            $display("FAIL random_activity: got 0 responses expected more than 0");
        end
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            sram[i]    = $urandom;
            exp_mem[i] = sram[i];
        end
        test_reset();
        test_read_after_write();
        test_byte_strobes();
        test_errors();
        test_back_pressure();
        test_streaming();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lnrv_itcm_rsp.md
Name: lnrv_itcm_rsp

Overview:
- Responder (slave) end of the core's cmd/rsp memory bus: the instruction-tightly-coupled memory port that the fetch unit issues commands to.
- Decodes and range-checks each command and drives a single-port synchronous SRAM macro with 1-cycle read latency.
- Returns one response per accepted command, in order, through a 2-entry response buffer.
- Sustains 1 command per cycle under no rsp back-pressure and absorbs rsp stalls without losing read data.

Parameters:
- ADDR_BASE, 32'h8000_0000, byte base address of the ITCM window.
- RAM_AW, 14, SRAM word-address width; window size is 4<<RAM_AW bytes (64 KiB at default).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- itcm_cmd_vld  in  1  command valid
- itcm_cmd_rdy  out  1  command ready
- itcm_cmd_write  in  1  1 = write, 0 = read
- itcm_cmd_addr  in  32  byte address
- itcm_cmd_wdata  in  32  write data
- itcm_cmd_wstrb  in  4  byte strobes
- itcm_rsp_vld  out  1  response valid
- itcm_rsp_rdy  in  1  response ready
- itcm_rsp_rdata  out  32  read data; 0 for writes and errors
- itcm_rsp_err  out  1  error response
- ram_cs  out  1  SRAM chip select
- ram_we  out  1  SRAM write enable
- ram_addr  out  RAM_AW  SRAM word address
- ram_wdata  out  32  SRAM write data
- ram_wem  out  4  SRAM byte write mask
- ram_rdata  in  32  SRAM read data, valid exactly the cycle after a read with ram_cs

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: inflight=0, buffer count=0, itcm_rsp_vld=0, itcm_rsp_rdata=0, itcm_rsp_err=0, ram_cs=0, ram_we=0.
- itcm_cmd_rdy is 1 in the first cycle after reset.
- Accept: a command is accepted in cycle T when itcm_cmd_vld & itcm_cmd_rdy.
- itcm_cmd_rdy = (inflight + count) < 2. It is registered-state only and has no combinational path from itcm_rsp_rdy.
- Error decode, evaluated in cycle T. err=1 if either holds:
  - addr[1:0] != 0;
  - (addr - ADDR_BASE) >= (4<<RAM_AW), computed as 32-bit unsigned (this covers addresses below base via wrap).
- SRAM drive, in cycle T:
  - ram_cs = accept & ~err.
  - ram_we = itcm_cmd_write.
  - ram_addr = (addr-ADDR_BASE)[RAM_AW+1:2].
  - ram_wdata = wdata.
  - ram_wem = wstrb when writing, else 0.
  - Erroring commands never touch the SRAM.
- In-flight stage: a register holds {valid, write, err} for the command accepted in T; it is occupied during T+1.
- T+1 response value:
  - rdata = ram_rdata for a non-error read, else 0.
  - err = the latched err.
- Bypass: if the buffer is empty in T+1, itcm_rsp_vld=1 in T+1 carrying the in-flight response; if itcm_rsp_rdy=1 it completes there.
- Otherwise the in-flight response is pushed into the 2-entry in-order FIFO at the end of T+1. ram_rdata is captured there and never re-sampled later.
- Response output when the FIFO is non-empty: itcm_rsp_vld/rdata/err come from the FIFO head. A pop occurs on itcm_rsp_vld & itcm_rsp_rdy.
- Latency: response earliest in T+1. Throughput is 1/cycle with itcm_rsp_rdy held at 1.
- Simultaneous push and pop: count is unchanged and ordering is preserved (head pops, new entry goes to the tail).
- Stability: while itcm_rsp_vld=1 and itcm_rsp_rdy=0, itcm_rsp_rdata and itcm_rsp_err hold stable.
- Zero strobes: a write with wstrb=0 still asserts ram_cs (ram_wem=0) and returns an OK response.
- Full: with inflight+count=2, itcm_cmd_rdy=0. No command is accepted and the SRAM stays idle.
- Reset mid-operation: in-flight and buffered responses are discarded. Outputs return to their reset values in the next cycle.

Test Plan:
- Read after write: write 0x8000_0010 wdata 0xDEADBEEF wstrb 0xF, then read the same address -> rsp0 rdata=0 err=0; rsp1 rdata=0xDEADBEEF err=0 one cycle after the read is accepted.
- Byte strobes: write 0x1122_3344 wstrb 0x5 over a word holding 0xFFFF_FFFF, then read -> 0xFF22_FF44.
- Errors, no SRAM access:
  - read 0x8001_0000 -> err=1, rdata=0, ram_cs never asserted;
  - read 0x7FFF_FFFC -> err=1;
  - read 0x8000_0002 -> err=1.
- Back-pressure: 4 back-to-back reads with itcm_rsp_rdy=0 -> itcm_cmd_rdy drops after 2 accepts. Raising itcm_rsp_rdy returns 2 correct responses in order, then the remaining reads are accepted.
- Streaming: 8 consecutive reads with itcm_rsp_rdy=1 -> itcm_cmd_rdy is constantly 1 and 8 responses arrive in 8 consecutive cycles with matching data.
- Reset mid-operation: assert reset while 2 responses are buffered -> itcm_rsp_vld=0 in the next cycle, itcm_cmd_rdy=1 after release, and no stale response is ever delivered.
